// File: rtl/vga_pkg.sv
// +--------------------------------------------------------------------------+
// | vga_pkg : shared pong display and game-flow constants, state and winner   |
// |           encodings used by the ball controller and score keeper.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package vga_pkg;

    localparam int HOR_PIXELS  = 1024;
    localparam int VER_PIXELS  = 768;
    localparam int BALL_SIZE   = 15;
    localparam int GOAL_MARGIN = 8;

    localparam int LEFT_GOAL_X_DEFAULT  = GOAL_MARGIN;
    localparam int RIGHT_GOAL_X_DEFAULT = HOR_PIXELS - BALL_SIZE - GOAL_MARGIN;

    // PLAY keeps the value the ball controller already compares against.
    typedef enum logic [1:0] {
        GS_IDLE  = 2'b00,
        GS_PLAY  = 2'b01,
        GS_SERVE = 2'b10,
        GS_OVER  = 2'b11
    } game_state_e;

    localparam logic [1:0] ST_IDLE  = 2'(GS_IDLE);
    localparam logic [1:0] ST_PLAY  = 2'(GS_PLAY);
    localparam logic [1:0] ST_SERVE = 2'(GS_SERVE);
    localparam logic [1:0] ST_OVER  = 2'(GS_OVER);

    localparam logic [1:0] WINNER_NONE  = 2'b00;
    localparam logic [1:0] WINNER_LEFT  = 2'b01;
    localparam logic [1:0] WINNER_RIGHT = 2'b10;

    localparam logic [3:0] SCORE_MAX = 4'hF;

endpackage

`default_nettype wire

// File: rtl/score_counter.sv
// +--------------------------------------------------------------------------+
// | score_counter : 4-bit saturating score counter with synchronous clear    |
// |                 (priority) and increment enable.                         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module score_counter
    import vga_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 4'd0;
        end else if (clr) begin
            count <= 4'd0;
        end else if (inc && (count != SCORE_MAX)) begin
            count <= count + 4'd1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/score_keeper.sv
// +--------------------------------------------------------------------------+
// | score_keeper : pong game-flow FSM, goal detection and scoring.           |
// |   Optional macro SCORE_KEEPER_WIN_BY_TWO_EN selects win-by-two rule.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module score_keeper
    import vga_pkg::*;
#(
    parameter int WIN_SCORE    = 7,
    parameter int PAUSE_TICKS  = 60,
    parameter int LEFT_GOAL_X  = LEFT_GOAL_X_DEFAULT,
    parameter int RIGHT_GOAL_X = RIGHT_GOAL_X_DEFAULT
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        timing_tick,
    input  logic        start_btn,
    input  logic [10:0] x_ball,
    output logic [1:0]  state,
    output logic [3:0]  score_left,
    output logic [3:0]  score_right,
    output logic [1:0]  winner,
    output logic        goal_pulse
);

    localparam int               PAUSE_W    = (PAUSE_TICKS > 1) ? $clog2(PAUSE_TICKS) : 1;
    localparam logic [PAUSE_W-1:0] PAUSE_LAST = PAUSE_W'(PAUSE_TICKS - 1);
    localparam logic [10:0]      LEFT_X     = 11'(LEFT_GOAL_X);
    localparam logic [10:0]      RIGHT_X    = 11'(RIGHT_GOAL_X);
    localparam logic [3:0]       WIN_VAL    = 4'(WIN_SCORE);

    logic               start_btn_q;
    logic [PAUSE_W-1:0] pause_cnt;

    logic       start_rise;
    logic       start_accept;
    logic       play_tick;
    logic       goal_right;
    logic       goal_left;
    logic [3:0] next_left;
    logic [3:0] next_right;
    logic       left_wins;
    logic       right_wins;

    assign start_rise   = start_btn & ~start_btn_q;
    assign start_accept = start_rise & ((state == ST_IDLE) | (state == ST_OVER));
    assign play_tick    = (state == ST_PLAY) & timing_tick;

    // Left edge has priority so a single tick can never score twice.
    assign goal_right = play_tick & (x_ball <= LEFT_X);
    assign goal_left  = play_tick & ~(x_ball <= LEFT_X) & (x_ball >= RIGHT_X);

    assign next_left  = (score_left  == SCORE_MAX) ? SCORE_MAX : score_left  + 4'd1;
    assign next_right = (score_right == SCORE_MAX) ? SCORE_MAX : score_right + 4'd1;

`ifdef SCORE_KEEPER_WIN_BY_TWO_EN
    // Reaching the saturation ceiling ends the game for the leader.
    assign left_wins  = ((next_left >= WIN_VAL) &&
                         ({1'b0, next_left} >= ({1'b0, score_right} + 5'd2))) ||
                        (next_left == SCORE_MAX);
    assign right_wins = ((next_right >= WIN_VAL) &&
                         ({1'b0, next_right} >= ({1'b0, score_left} + 5'd2))) ||
                        (next_right == SCORE_MAX);
`else
    assign left_wins  = (next_left  == WIN_VAL);
    assign right_wins = (next_right == WIN_VAL);
`endif

    score_counter u_score_left (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start_accept),
        .inc   (goal_left),
        .count (score_left)
    );

    score_counter u_score_right (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start_accept),
        .inc   (goal_right),
        .count (score_right)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_btn_q <= 1'b0;
        end else begin
            start_btn_q <= start_btn;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            winner     <= WINNER_NONE;
            goal_pulse <= 1'b0;
            pause_cnt  <= '0;
        end else begin
            goal_pulse <= 1'b0;
            case (state)
                ST_IDLE, ST_OVER: begin
                    if (start_rise) begin
                        state     <= ST_SERVE;
                        winner    <= WINNER_NONE;
                        pause_cnt <= '0;
                    end
                end
                ST_SERVE: begin
                    if (timing_tick) begin
                        if (pause_cnt == PAUSE_LAST) begin
                            pause_cnt <= '0;
                            state     <= ST_PLAY;
                        end else begin
                            pause_cnt <= pause_cnt + 1'b1;
                        end
                    end
                end
                ST_PLAY: begin
                    // Leaving PLAY on the goal tick recentres the ball, preventing a recount.
                    if (goal_right) begin
                        goal_pulse <= 1'b1;
                        if (right_wins) begin
                            state  <= ST_OVER;
                            winner <= WINNER_RIGHT;
                        end else begin
                            state  <= ST_SERVE;
                        end
                    end else if (goal_left) begin
                        goal_pulse <= 1'b1;
                        if (left_wins) begin
                            state  <= ST_OVER;
                            winner <= WINNER_LEFT;
                        end else begin
                            state  <= ST_SERVE;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_score_keeper.sv
// +--------------------------------------------------------------------------+
// | tb_score_keeper : directed and randomized self-checking bench for        |
// |                   score_keeper against a behavioural game model.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_score_keeper;

    localparam int WIN   = 7;
    localparam int PAUSE = 60;
    localparam int LGX   = 8;
    localparam int RGX   = 1001;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        timing_tick = 1'b0;
    logic        start_btn = 1'b0;
    logic [10:0] x_ball = 11'd500;
    logic [1:0]  state;
    logic [3:0]  score_left;
    logic [3:0]  score_right;
    logic [1:0]  winner;
    logic        goal_pulse;

    int checks = 0;
    int errors = 0;

    // Behavioural game model: phase names, point tallies, ticks waited.
    int  m_phase;   // 0 idle, 1 play, 2 serve, 3 over
    int  m_left, m_right, m_winner, m_waited;
    bit  m_pulse, m_btn_prev;

    score_keeper #(
        .WIN_SCORE    (WIN),
        .PAUSE_TICKS  (PAUSE),
        .LEFT_GOAL_X  (LGX),
        .RIGHT_GOAL_X (RGX)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .timing_tick (timing_tick),
        .start_btn   (start_btn),
        .x_ball      (x_ball),
        .state       (state),
        .score_left  (score_left),
        .score_right (score_right),
        .winner      (winner),
        .goal_pulse  (goal_pulse)
    );

    always #5 clk = ~clk;

    function automatic bit wins(int mine, int other);
`ifdef SCORE_KEEPER_WIN_BY_TWO_EN
        return ((mine >= WIN) && (mine >= other + 2)) || (mine == 15);
`else
        return mine == WIN;
`endif
    endfunction

    task automatic model_reset();
        m_phase = 0; m_left = 0; m_right = 0; m_winner = 0;
        m_waited = 0; m_pulse = 0; m_btn_prev = 0;
    endtask

    task automatic model_clock(bit tick, bit btn, int x);
        bit pressed;
        pressed = btn && !m_btn_prev;
        m_btn_prev = btn;
        m_pulse = 0;
        if (m_phase == 0 || m_phase == 3) begin
            if (pressed) begin
                m_left = 0; m_right = 0; m_winner = 0; m_waited = 0; m_phase = 2;
            end
        end else if (m_phase == 2) begin
            if (tick) begin
                m_waited++;
                if (m_waited == PAUSE) begin
                    m_waited = 0; m_phase = 1;
                end
            end
        end else if (tick) begin
            if (x <= LGX) begin
                if (m_right < 15) m_right++;
                m_pulse = 1;
                if (wins(m_right, m_left)) begin m_phase = 3; m_winner = 2; end
                else m_phase = 2;
            end else if (x >= RGX) begin
                if (m_left < 15) m_left++;
                m_pulse = 1;
                if (wins(m_left, m_right)) begin m_phase = 3; m_winner = 1; end
                else m_phase = 2;
            end
        end
    endtask

    task automatic check(string tag, int obs, int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        check({tag, ".state"},  int'(state),       m_phase);
        check({tag, ".left"},   int'(score_left),  m_left);
        check({tag, ".right"},  int'(score_right), m_right);
        check({tag, ".winner"}, int'(winner),      m_winner);
        check({tag, ".pulse"},  int'(goal_pulse),  int'(m_pulse));
    endtask

    task automatic step(string tag, bit tick, bit btn, int x);
        @(negedge clk);
        timing_tick = tick;
        start_btn   = btn;
        x_ball      = 11'(x);
        @(posedge clk);
        model_clock(tick, btn, x);
        #1;
        check_all(tag);
    endtask

    task automatic press_start(string tag);
        step(tag, 1'b0, 1'b1, 500);
        step(tag, 1'b0, 1'b0, 500);
    endtask

    task automatic serve_ticks(string tag, int n);
        for (int i = 0; i < n; i++) step(tag, 1'b1, 1'b0, 500);
    endtask

    task automatic goal(string tag, int x);
        step(tag, 1'b1, 1'b0, x);
        step(tag, 1'b0, 1'b0, 500);
    endtask

    function automatic int rand_x();
        case ($urandom_range(0, 4))
            0:       return $urandom_range(0, LGX);
            1:       return $urandom_range(RGX, 2047);
            2:       return $urandom_range(LGX - 1, LGX + 2);
            3:       return $urandom_range(RGX - 2, RGX + 1);
            default: return $urandom_range(LGX + 1, RGX - 1);
        endcase
    endfunction

    initial begin
        model_reset();
        #12;
        check_all("reset");
        rst_n = 1'b1;

        // Start, then exactly PAUSE ticks of serve before play.
        press_start("start");
        serve_ticks("serve", PAUSE - 1);
        check("serve_before_last", int'(state), 2);
        serve_ticks("serve_last", 1);
        check("play_after_pause", int'(state), 1);

        // Right goal, then held ball must not recount while serving.
        step("goal_r", 1'b1, 1'b0, 5);
        check("goal_r_pulse", int'(goal_pulse), 1);
        step("goal_r_hold1", 1'b1, 1'b0, 5);
        step("goal_r_hold2", 1'b1, 1'b0, 5);
        step("goal_r_hold3", 1'b1, 1'b0, 5);
        check("no_double_count", int'(score_right), 1);
        serve_ticks("serve2", PAUSE - 3);

        // Edge boundaries: 1001 scores, 1000 does not, 8 without tick does not.
        step("x1000", 1'b1, 1'b0, 1000);
        step("x8_notick", 1'b0, 1'b0, 8);
        goal("x1001", 1001);
        check("left_after_1001", int'(score_left), 1);

        // Left runs to the win.
        while (m_phase != 3) begin
            serve_ticks("serve_run", PAUSE);
            goal("left_run", 1500);
        end
        press_start("restart");

        // Build 3/2 then reset asynchronously mid-play.
        for (int g = 0; g < 5; g++) begin
            serve_ticks("serve_32", PAUSE);
            goal("goal_32", (g < 3) ? 1800 : 0);
        end
        serve_ticks("serve_play", PAUSE);
        check("mid_play_state", int'(state), 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized play against the model.
        for (int i = 0; i < 6000; i++) begin
            step("rand", ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0), rand_x());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL timeout: observed running expected finished");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
